// File: rtl/in_capture_pkg.sv
// Shared types and constants for the switch/button input capture path.
package in_capture_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        ACK          = 2'd2,
        WAIT_RELEASE = 2'd3
    } state_e;

    // The board pushbutton is active-low, so the idle level is 1.
    localparam logic BTN_RELEASED = 1'b1;
    localparam int   SW_W         = 16;

endpackage

// File: rtl/in_capture_if.sv
// Board-side raw inputs and the CPU IN-instruction handshake, grouped as one bus.
interface in_capture_if;
    import in_capture_pkg::*;

    logic            button_raw;
    logic [SW_W-1:0] switches_raw;
    logic            in_req;
    logic [SW_W-1:0] switches;
    logic            button_in;
    logic            in_ack;
    logic            waiting;

    modport master (
        output button_raw, switches_raw, in_req,
        input  switches, button_in, in_ack, waiting
    );

    modport slave (
        input  button_raw, switches_raw, in_req,
        output switches, button_in, in_ack, waiting
    );

endinterface

// File: rtl/in_debounce.sv
// Single-bit two-flop synchronizer plus stable-count debouncer with registered edge strobes.
module in_debounce
    import in_capture_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter int   CNT_W           = 20,
    parameter logic RESET_LEVEL     = BTN_RELEASED
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;

    assign w_differs = (r_sync2 != r_level);
    assign level     = r_level;
    assign rise      = r_rise;
    assign fall      = r_fall;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sync1 <= RESET_LEVEL;
            r_sync2 <= RESET_LEVEL;
            r_level <= RESET_LEVEL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_LAST) begin
                // This edge would make the count reach DEBOUNCE_CYCLES: accept the new level.
                r_level <= ~r_level;
                r_rise  <= ~r_level;
                r_fall  <= r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/in_capture.sv
// Debounced pushbutton / slide-switch capture answering the CPU IN handshake.
//
// state        | meaning
// IDLE         | no IN pending; button presses ignored
// WAIT_PRESS   | IN pending, waiting LED on, waiting for a debounced press
// ACK          | one-cycle button_in/in_ack strobe, switches just latched
// WAIT_RELEASE | hold off further IN requests until the button is released
module in_capture
    import in_capture_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic         clock,
    input  logic         reset_n,
    in_capture_if.slave  bus
);

    logic [SW_W-1:0] r_sw_sync1;
    logic [SW_W-1:0] r_sw_sync2;
    logic [SW_W-1:0] r_switches;
    logic            r_button_in;
    logic            r_in_ack;
    logic            r_waiting;
    state_e          r_state;

    logic            w_btn_level;
    logic            w_btn_press;
    logic            w_btn_rise_unused;

    in_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .RESET_LEVEL     (BTN_RELEASED)
    ) u_btn (
        .clock   (clock),
        .reset_n (reset_n),
        .raw     (bus.button_raw),
        .level   (w_btn_level),
        .rise    (w_btn_rise_unused),
        .fall    (w_btn_press)
    );

    assign bus.switches  = r_switches;
    assign bus.button_in = r_button_in;
    assign bus.in_ack    = r_in_ack;
    assign bus.waiting   = r_waiting;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_sw_sync1 <= '0;
            r_sw_sync2 <= '0;
        end else begin
            r_sw_sync1 <= bus.switches_raw;
            r_sw_sync2 <= r_sw_sync1;
        end
    end

    // Outputs are registered alongside the state so they are glitch-free Moore outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_switches  <= '0;
            r_button_in <= 1'b0;
            r_in_ack    <= 1'b0;
            r_waiting   <= 1'b0;
        end else begin
            r_button_in <= 1'b0;
            r_in_ack    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.in_req) begin
                        r_state   <= WAIT_PRESS;
                        r_waiting <= 1'b1;
                    end
                end
                WAIT_PRESS: begin
                    // An abort takes priority over a press arriving on the same edge.
                    if (!bus.in_req) begin
                        r_state   <= IDLE;
                        r_waiting <= 1'b0;
                    end else if (w_btn_press) begin
                        r_state     <= ACK;
                        r_waiting   <= 1'b0;
                        r_button_in <= 1'b1;
                        r_in_ack    <= 1'b1;
                        r_switches  <= r_sw_sync2;
                    end
                end
                ACK: begin
                    r_state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (w_btn_level == BTN_RELEASED) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_waiting <= 1'b0;
                end
            endcase
        end
    end

endmodule
